// File: rtl/vend_controller_if.sv
// Coin, selection and dispenser/change-return signal bundle around vend_controller.
// slave = controller side; master = machine side (coin acceptor, keypad, dispensers).
interface vend_controller_if;
    logic       fiveKurus;
    logic       tenKurus;
    logic       twentyFiveKurus;
    logic [1:0] select;
    logic       selValid;
    logic       cancel;
    logic       vendReq;
    logic [1:0] productId;
    logic       vendAck;
    logic       changeReq;
    logic       changeAck;
    logic [6:0] credit;
    logic       busy;
    logic       coinReject;
    logic       selError;

    modport master (
        output fiveKurus, tenKurus, twentyFiveKurus, select, selValid, cancel,
               vendAck, changeAck,
        input  vendReq, productId, changeReq, credit, busy, coinReject, selError
    );

    modport slave (
        input  fiveKurus, tenKurus, twentyFiveKurus, select, selValid, cancel,
               vendAck, changeAck,
        output vendReq, productId, changeReq, credit, busy, coinReject, selError
    );
endinterface

// File: rtl/vend_controller.sv
// Vending controller (IDLE/COLLECT/VEND/CHANGE); credit and flags update one edge after the event, waits indefinitely on vendAck/changeAck.
// Optional COLLECT idle auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
    parameter int PRICE0         = 30,
    parameter int PRICE1         = 45,
    parameter int PRICE2         = 60,
    parameter int PRICE3         = 85,
    parameter int MAX_CREDIT     = 95,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              resetN,
    vend_controller_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t     state, stateNext;
    logic [6:0] creditQ, creditNext;
    logic [1:0] productQ, productNext;
    logic       coinRejectQ, coinRejectNext;
    logic       selErrorQ, selErrorNext;

    logic       coinEvent;
    logic       coinFits;
    logic [6:0] coinValue;
    logic [7:0] coinSum;
    logic [6:0] selPrice;
    logic [6:0] vendPrice;
    logic       timeoutHit;

    function automatic logic [6:0] priceOf(input logic [1:0] idx);
        case (idx)
            2'd0:    priceOf = 7'(PRICE0);
            2'd1:    priceOf = 7'(PRICE1);
            2'd2:    priceOf = 7'(PRICE2);
            default: priceOf = 7'(PRICE3);
        endcase
    endfunction

    always_comb begin
        coinValue = 7'd0;
        if (bus.fiveKurus)            coinValue = 7'd5;
        else if (bus.tenKurus)        coinValue = 7'd10;
        else if (bus.twentyFiveKurus) coinValue = 7'd25;
    end

    assign coinEvent = bus.fiveKurus | bus.tenKurus | bus.twentyFiveKurus;
    assign coinSum   = {1'b0, creditQ} + {1'b0, coinValue};
    // Simultaneous coin lines are ambiguous and always refused.
    assign coinFits  = $onehot({bus.fiveKurus, bus.tenKurus, bus.twentyFiveKurus})
                       && (coinSum <= 8'(MAX_CREDIT));
    assign selPrice  = priceOf(bus.select);
    assign vendPrice = priceOf(productQ);

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idleTimer;
    logic          quietCycle;

    assign quietCycle = (state == COLLECT) && !coinEvent && !bus.selValid && !bus.cancel;
    assign timeoutHit = quietCycle && (idleTimer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)                    idleTimer <= '0;
        else if (quietCycle && !timeoutHit) idleTimer <= idleTimer + 1'b1;
        else                            idleTimer <= '0;
    end
`else
    // No timer: a non-negative timeout can never fire, so COLLECT waits forever.
    assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        stateNext      = state;
        creditNext     = creditQ;
        productNext    = productQ;
        coinRejectNext = coinEvent;
        selErrorNext   = 1'b0;
        case (state)
            IDLE: begin
                if (coinFits) begin
                    creditNext     = coinSum[6:0];
                    coinRejectNext = 1'b0;
                    stateNext      = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.cancel) begin
                    stateNext = CHANGE;
                end else if (bus.selValid && (creditQ >= selPrice)) begin
                    productNext = bus.select;
                    stateNext   = VEND;
                end else begin
                    selErrorNext = bus.selValid;
                    if (timeoutHit) begin
                        stateNext = CHANGE;
                    end else if (coinFits) begin
                        creditNext     = coinSum[6:0];
                        coinRejectNext = 1'b0;
                    end
                end
            end
            VEND: begin
                if (bus.vendAck) begin
                    creditNext = creditQ - vendPrice;
                    stateNext  = (creditQ != vendPrice) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (bus.changeAck) begin
                    if (creditQ <= 7'd5) begin
                        creditNext = 7'd0;
                        stateNext  = IDLE;
                    end else begin
                        creditNext = creditQ - 7'd5;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            creditQ     <= '0;
            productQ    <= '0;
            coinRejectQ <= 1'b0;
            selErrorQ   <= 1'b0;
        end else begin
            state       <= stateNext;
            creditQ     <= creditNext;
            productQ    <= productNext;
            coinRejectQ <= coinRejectNext;
            selErrorQ   <= selErrorNext;
        end
    end

    assign bus.vendReq    = (state == VEND);
    assign bus.changeReq  = (state == CHANGE);
    assign bus.busy       = (state == VEND) || (state == CHANGE);
    assign bus.credit     = creditQ;
    assign bus.productId  = productQ;
    assign bus.coinReject = coinRejectQ;
    assign bus.selError   = selErrorQ;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus a randomized run against a credit-level model.
module tb_vend_controller;
    localparam int P0 = 30, P1 = 45, P2 = 60, P3 = 85, MAXC = 95, TMO = 8;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vend_controller_if bus();

    vend_controller #(
        .PRICE0(P0), .PRICE1(P1), .PRICE2(P2), .PRICE3(P3),
        .MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic int priceOf(input int idx);
        case (idx)
            0:       return P0;
            1:       return P1;
            2:       return P2;
            default: return P3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        bus.fiveKurus = 0; bus.tenKurus = 0; bus.twentyFiveKurus = 0;
        bus.select = 2'd0; bus.selValid = 0; bus.cancel = 0;
        bus.vendAck = 0; bus.changeAck = 0;
    endtask

    task automatic coin(input int value);
        bus.fiveKurus = (value == 5);
        bus.tenKurus = (value == 10);
        bus.twentyFiveKurus = (value == 25);
        tick();
        clearInputs();
    endtask

    // Return the machine to an empty idle state within a bounded number of cycles.
    task automatic drain();
        clearInputs();
        if (!bus.busy && bus.credit != 0) begin
            bus.cancel = 1;
            tick();
            bus.cancel = 0;
        end
        for (int i = 0; i < 40; i++) begin
            if (!bus.vendReq && !bus.changeReq) break;
            bus.vendAck = 1;
            bus.changeAck = 1;
            tick();
        end
        clearInputs();
        checks++;
        if (bus.vendReq || bus.changeReq || bus.credit !== 7'd0) begin
            errors++;
            $display("FAIL drain: vendReq=%0b changeReq=%0b credit=%0d, required idle with credit 0",
                     bus.vendReq, bus.changeReq, bus.credit);
        end
    endtask

    task automatic test_reset();
        clearInputs();
        resetN = 0;
        #2;
        checks++;
        if ({bus.vendReq, bus.changeReq, bus.busy, bus.coinReject, bus.selError} !== 5'b0 ||
            bus.credit !== 7'd0 || bus.productId !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: vend=%0b chg=%0b busy=%0b rej=%0b selErr=%0b credit=%0d pid=%0d, required all 0",
                     bus.vendReq, bus.changeReq, bus.busy, bus.coinReject, bus.selError, bus.credit, bus.productId);
        end
        tick();
        resetN = 1;
        tick();
    endtask

    task automatic test_vend_flow();
        int reqCycles = 0;
        coin(25);
        coin(10);
        checks++;
        if (bus.credit !== 7'd35 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flow_credit35: credit=%0d busy=%0b, required 35/0", bus.credit, bus.busy);
        end
        bus.select = 2'd0; bus.selValid = 1;
        tick();
        clearInputs();
        for (int i = 0; i < 3; i++) begin
            if (bus.vendReq) reqCycles++;
            checks++;
            if (bus.productId !== 2'd0 || bus.credit !== 7'd35 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL flow_vend_hold: pid=%0d credit=%0d busy=%0b, required 0/35/1",
                         bus.productId, bus.credit, bus.busy);
            end
            if (i == 2) bus.vendAck = 1;
            tick();
        end
        clearInputs();
        checks++;
        if (reqCycles != 3) begin
            errors++;
            $display("FAIL flow_vendReq_cycles: %0d, required 3", reqCycles);
        end
        checks++;
        if (bus.vendReq !== 1'b0 || bus.changeReq !== 1'b1 || bus.credit !== 7'd5) begin
            errors++;
            $display("FAIL flow_after_ack: vend=%0b chg=%0b credit=%0d, required 0/1/5",
                     bus.vendReq, bus.changeReq, bus.credit);
        end
        bus.changeAck = 1;
        tick();
        clearInputs();
        checks++;
        if (bus.changeReq !== 1'b0 || bus.credit !== 7'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flow_change_done: chg=%0b credit=%0d busy=%0b, required 0/0/0",
                     bus.changeReq, bus.credit, bus.busy);
        end
    endtask

    task automatic test_sel_error_cancel();
        coin(10);
        bus.select = 2'd1; bus.selValid = 1;
        tick();
        clearInputs();
        checks++;
        if (bus.selError !== 1'b1 || bus.credit !== 7'd10 || bus.vendReq !== 1'b0) begin
            errors++;
            $display("FAIL selerr_pulse: selError=%0b credit=%0d vend=%0b, required 1/10/0",
                     bus.selError, bus.credit, bus.vendReq);
        end
        tick();
        checks++;
        if (bus.selError !== 1'b0) begin
            errors++;
            $display("FAIL selerr_one_cycle: selError=%0b, required 0", bus.selError);
        end
        bus.cancel = 1;
        tick();
        clearInputs();
        checks++;
        if (bus.changeReq !== 1'b1 || bus.credit !== 7'd10) begin
            errors++;
            $display("FAIL cancel_change: chg=%0b credit=%0d, required 1/10", bus.changeReq, bus.credit);
        end
        bus.changeAck = 1;
        tick();
        checks++;
        if (bus.credit !== 7'd5 || bus.changeReq !== 1'b1) begin
            errors++;
            $display("FAIL cancel_first_ack: credit=%0d chg=%0b, required 5/1", bus.credit, bus.changeReq);
        end
        tick();
        clearInputs();
        checks++;
        if (bus.credit !== 7'd0 || bus.changeReq !== 1'b0) begin
            errors++;
            $display("FAIL cancel_second_ack: credit=%0d chg=%0b, required 0/0", bus.credit, bus.changeReq);
        end
    endtask

    task automatic test_overflow();
        coin(25); coin(25); coin(25); coin(10); coin(5);
        checks++;
        if (bus.credit !== 7'd90) begin
            errors++;
            $display("FAIL ovf_build: credit=%0d, required 90", bus.credit);
        end
        coin(10);
        checks++;
        if (bus.coinReject !== 1'b1 || bus.credit !== 7'd90) begin
            errors++;
            $display("FAIL ovf_reject: rej=%0b credit=%0d, required 1/90", bus.coinReject, bus.credit);
        end
        tick();
        checks++;
        if (bus.coinReject !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reject_pulse: rej=%0b, required 0", bus.coinReject);
        end
        bus.fiveKurus = 1; bus.tenKurus = 1;
        tick();
        clearInputs();
        checks++;
        if (bus.coinReject !== 1'b1 || bus.credit !== 7'd90) begin
            errors++;
            $display("FAIL multi_coin_reject: rej=%0b credit=%0d, required 1/90", bus.coinReject, bus.credit);
        end
        drain();
    endtask

    task automatic test_priority();
        coin(25); coin(5);
        bus.cancel = 1; bus.selValid = 1; bus.select = 2'd0; bus.fiveKurus = 1;
        tick();
        clearInputs();
        checks++;
        if (bus.changeReq !== 1'b1 || bus.vendReq !== 1'b0 || bus.coinReject !== 1'b1 || bus.credit !== 7'd30) begin
            errors++;
            $display("FAIL priority: chg=%0b vend=%0b rej=%0b credit=%0d, required 1/0/1/30",
                     bus.changeReq, bus.vendReq, bus.coinReject, bus.credit);
        end
        drain();
    endtask

    task automatic test_reset_mid_vend();
        coin(25); coin(10); coin(10);
        bus.select = 2'd1; bus.selValid = 1;
        tick();
        clearInputs();
        checks++;
        if (bus.vendReq !== 1'b1 || bus.credit !== 7'd45) begin
            errors++;
            $display("FAIL midvend_enter: vend=%0b credit=%0d, required 1/45", bus.vendReq, bus.credit);
        end
        resetN = 0;
        #1;
        checks++;
        if (bus.vendReq !== 1'b0 || bus.credit !== 7'd0 || bus.busy !== 1'b0 || bus.changeReq !== 1'b0) begin
            errors++;
            $display("FAIL midvend_reset: vend=%0b credit=%0d busy=%0b chg=%0b, required 0/0/0/0",
                     bus.vendReq, bus.credit, bus.busy, bus.changeReq);
        end
        #2;
        resetN = 1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.credit !== 7'd0) begin
            errors++;
            $display("FAIL midvend_no_resume: busy=%0b credit=%0d, required 0/0", bus.busy, bus.credit);
        end
    endtask

    task automatic test_timeout();
        bit expChg;
        coin(5);
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef VEND_TIMEOUT_EN
            expChg = (k >= TMO) && (bus.credit != 0);
            if (k > TMO) break;
`else
            expChg = 1'b0;
`endif
            checks++;
            if (bus.changeReq !== expChg) begin
                errors++;
                $display("FAIL timeout_k%0d: chg=%0b, required %0b", k, bus.changeReq, expChg);
            end
        end
        drain();
    endtask

    task automatic test_random();
        int  mCredit = 0, mVendPrice = -1, mProd = 0;
        bit  mRefund = 0, expReject = 0, expSelErr = 0;
        int  nCoins, val, r;
        bit  accept, coinEv;
`ifdef VEND_TIMEOUT_EN
        int  mQuiet = 0;
`endif
        resetN = 0;
        #3;
        resetN = 1;
        tick();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            bus.fiveKurus = (r == 0) || (r == 3);
            bus.tenKurus = (r == 1) || (r == 3);
            bus.twentyFiveKurus = (r == 2);
            bus.select = 2'($urandom_range(0, 3));
            bus.selValid = ($urandom_range(0, 5) == 0);
            bus.cancel = ($urandom_range(0, 15) == 0);
            bus.vendAck = ($urandom_range(0, 2) == 0);
            bus.changeAck = ($urandom_range(0, 1) == 0);

            checks++;
            if (bus.credit !== 7'(mCredit) || bus.vendReq !== (mVendPrice >= 0) || bus.changeReq !== mRefund ||
                bus.busy !== ((mVendPrice >= 0) || mRefund) || bus.coinReject !== expReject ||
                bus.selError !== expSelErr || (mVendPrice >= 0 && bus.productId !== 2'(mProd))) begin
                errors++;
                $display("FAIL random_%0d: credit=%0d/%0d vend=%0b/%0b chg=%0b/%0b rej=%0b/%0b selErr=%0b/%0b pid=%0d/%0d (actual/required)",
                         i, bus.credit, mCredit, bus.vendReq, (mVendPrice >= 0), bus.changeReq, mRefund,
                         bus.coinReject, expReject, bus.selError, expSelErr, bus.productId, mProd);
            end

            nCoins = int'(bus.fiveKurus) + int'(bus.tenKurus) + int'(bus.twentyFiveKurus);
            val = bus.fiveKurus ? 5 : bus.tenKurus ? 10 : bus.twentyFiveKurus ? 25 : 0;
            coinEv = (nCoins > 0);
            accept = 0;
            expSelErr = 0;
            if (mVendPrice >= 0) begin
                if (bus.vendAck) begin
                    mCredit -= mVendPrice;
                    mVendPrice = -1;
                    mRefund = (mCredit > 0);
                end
            end else if (mRefund) begin
                if (bus.changeAck) begin
                    mCredit -= 5;
                    if (mCredit == 0) mRefund = 0;
                end
            end else if (mCredit == 0) begin
                accept = (nCoins == 1) && (val <= MAXC);
            end else if (bus.cancel) begin
                mRefund = 1;
            end else if (bus.selValid && mCredit >= priceOf(int'(bus.select))) begin
                mVendPrice = priceOf(int'(bus.select));
                mProd = int'(bus.select);
            end else begin
                expSelErr = bus.selValid;
                accept = (nCoins == 1) && (mCredit + val <= MAXC);
`ifdef VEND_TIMEOUT_EN
                if (!coinEv && !bus.selValid) begin
                    mQuiet++;
                    if (mQuiet == TMO) mRefund = 1;
                end
`endif
            end
`ifdef VEND_TIMEOUT_EN
            if (mRefund || mVendPrice >= 0 || mCredit == 0 || coinEv || bus.selValid || bus.cancel) mQuiet = 0;
`endif
            if (accept) mCredit += val;
            expReject = coinEv && !accept;
            tick();
        end
        drain();
    endtask

    initial begin
        clearInputs();
        test_reset();
        test_vend_flow();
        test_sel_error_cancel();
        test_overflow();
        test_priority();
        test_reset_mid_vend();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL expose parameter PRICE0, default 30, kurus price of product 0.
REQ-002 SHALL expose parameters PRICE1/PRICE2/PRICE3, defaults 45/60/85, kurus prices of products 1-3; all prices are multiples of 5.
REQ-003 SHALL expose parameter MAX_CREDIT, default 95, highest accepted credit in kurus.
REQ-004 SHALL expose parameter TIMEOUT_CYCLES, default 1000, COLLECT idle cycles before auto-refund.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports fiveKurus/tenKurus/twentyFiveKurus  input  1 each  one-cycle coin pulses.
REQ-008 SHALL have ports select  input  2  product index; selValid  input  1  selection strobe; cancel  input  1  refund request.
REQ-009 SHALL have ports vendReq  output  1, productId  output  2, vendAck  input  1  product dispenser handshake.
REQ-010 SHALL have ports changeReq  output  1, changeAck  input  1  5-kurus coin-return handshake.
REQ-011 SHALL have ports credit  output  7  current credit; busy  output  1; coinReject  output  1; selError  output  1.

Function
REQ-012 SHALL implement states IDLE, COLLECT, VEND, CHANGE; busy = 1 in VEND and CHANGE.
REQ-013 SHALL accept a coin only when exactly one coin line is high, state is IDLE or COLLECT, and credit+value <= MAX_CREDIT; credit updates at the next edge.
REQ-014 SHALL pulse coinReject for one cycle, one cycle after any coin event not accepted (multiple lines, busy, overflow, or lost to REQ-017); credit unchanged.
REQ-015 SHALL move IDLE -> COLLECT on the first accepted coin.
REQ-016 SHALL, in COLLECT on selValid, compare registered credit with PRICE[select]: >= -> VEND with productId latched; < -> stay, selError pulses one cycle.
REQ-017 SHALL prioritise cancel > selValid > coin in COLLECT; a coin in the same cycle as an acted-on cancel or valid-and-sufficient select is rejected.
REQ-018 SHALL, on cancel in COLLECT, go to CHANGE; cancel and selValid in IDLE are ignored (no selError).
REQ-019 SHALL hold vendReq = 1 and productId stable throughout VEND until vendAck; on vendAck, credit -= price and go to CHANGE if remainder > 0, else IDLE; vendReq low the following cycle.
REQ-020 SHALL hold changeReq = 1 throughout CHANGE; each cycle with changeAck high decrements credit by 5; when credit reaches 0, go to IDLE with changeReq low the following cycle.
REQ-021 SHALL ignore vendAck outside VEND and changeAck outside CHANGE.
REQ-022 SHALL keep credit constant while waiting indefinitely for vendAck/changeAck.

Reset
REQ-023 SHALL, on resetN low, immediately force state IDLE, credit 0, vendReq/changeReq/productId/coinReject/selError 0, idle timer 0, regardless of state.
REQ-024 SHALL discard credit when reset occurs mid-VEND or mid-CHANGE (no resumption).

Configuration
REQ-025 SHALL, with macro VEND_TIMEOUT_EN defined, count COLLECT cycles with no coin/selValid/cancel event and enter CHANGE on reaching TIMEOUT_CYCLES; counter clears on any such event or state exit.
REQ-026 SHALL, without VEND_TIMEOUT_EN, omit the timer entirely; COLLECT exits only via cancel or valid select.

Verification
REQ-027 SHALL cover: 25+10 coins, select=0, vendAck after 3 cycles -> vendReq 3 cycles, productId 0, credit 35->5, one changeAck -> credit 0, IDLE.
REQ-028 SHALL cover: 10 coin, select=1 -> selError one pulse, credit stays 10; cancel -> two changeAck cycles, credit 10->5->0.
REQ-029 SHALL cover: credit 90, 10 coin -> coinReject, credit 90; five+ten same cycle -> coinReject, credit unchanged.
REQ-030 SHALL cover: cancel, selValid, and 5 coin same cycle at credit 30 -> CHANGE, coinReject, no vendReq.
REQ-031 SHALL cover: resetN low mid-VEND at credit 45 -> vendReq 0, credit 0, IDLE same cycle.
REQ-032 SHALL cover (VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8): one 5 coin then 8 quiet cycles -> changeReq asserts; without macro -> stays COLLECT.
